bcd_pulse_gen: RTL and testbench
================================

// Module: bcd_pulse_gen
// PURPOSE
//  Inverse of the decade counter. It loads an NDIGITS-digit BCD count and emits exactly
//  that many one-cycle pulses on pulse_out, then signals done.
//  Internally it is a cascade of mod-10 down-counting digits, with a borrow from each digit
//  into the next and a programmable pulse spacing.
//  Sits between the BCD count/display path and any block that consumes pulse trains.
// PARAMETERS
//  NDIGITS  2  number of cascaded BCD digits; max count = 10^NDIGITS-1
//  PERIOD   1  clocks between pulse starts (>=1); PERIOD=1 gives back-to-back pulses
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-high
//  start      in   1          load bcd_in and begin; sampled in IDLE only
//  bcd_in     in   4*NDIGITS  BCD count to emit; digit i is bits [4i+3:4i], digit 0 = LS
//  hold       in   1          pause: freezes prescaler and remaining while high
//  abort      in   1          synchronous stop: RUN -> IDLE, no done
//  pulse_out  out  1          one-cycle pulse, registered
//  remaining  out  4*NDIGITS  BCD pulses still to emit, registered
//  busy       out  1          high while state == RUN
//  done       out  1          one-cycle completion strobe
//  err        out  1          one-cycle strobe: start with an invalid digit (>9)
// BEHAVIOUR
//  Reset (async, immediate, also mid-run):
//   state=IDLE; remaining=0; prescaler=0; pulse_out=busy=done=err=0. No done is produced.
//  States: IDLE, RUN, DONE. Outputs are registered; busy=(state==RUN); done=(state==DONE).
//  IDLE, start=1 at edge k:
//   - any digit of bcd_in >9: err=1 for cycle k+1; stay IDLE; remaining unchanged
//   - bcd_in==0: -> DONE (done high in cycle k+1); no pulses
//   - otherwise: remaining<=bcd_in; prescaler<=0; -> RUN
//  RUN, per edge (priority abort > hold > count):
//   - abort: -> IDLE; pulse_out<=0; remaining keeps its current value
//   - hold: prescaler, remaining and state frozen; pulse_out<=0
//   - prescaler==PERIOD-1: pulse_out<=1; prescaler<=0; remaining<=BCD decrement
//     - if remaining was 1: -> DONE on the same edge (last pulse and done share a cycle)
//   - otherwise: prescaler<=prescaler+1; pulse_out<=0
//  DONE: lasts exactly 1 cycle, then IDLE. start is ignored in DONE and RUN.
//  Latency: start at edge k -> first pulse_out high after edge k+PERIOD.
//   Pulses repeat every PERIOD cycles; extend by the hold cycles when hold is used.
//  BCD decrement per digit:
//   - digit 0 -> 9 and borrow to the next digit; a digit receiving no borrow is unchanged
//   - digits always stay within 0..9
//  Widths: prescaler is clog2(PERIOD)+1 bits wide; it is unused (always pulses) when PERIOD=1.
//  Total pulses emitted = decimal value of bcd_in, exactly, absent abort or reset.
// TESTING
//  1 NDIGITS=2 PERIOD=1, start bcd_in=8'h12 -> 12 consecutive pulses;
//    remaining 12,11,10,09..01,00; busy for 12 cycles; done in the 12th pulse cycle.
//  2 PERIOD=3, bcd_in=8'h03 -> pulses after edges k+3, k+6, k+9; done with the 3rd pulse;
//    no other pulse_out highs.
//  3 bcd_in=8'h00 -> done for 1 cycle at k+1, zero pulses, busy never high;
//    bcd_in=8'h1A -> err 1 cycle, busy never high, no pulses.
//  4 PERIOD=1, bcd_in=8'h05, hold high 4 cycles after the 2nd pulse
//    -> remaining frozen at 03, no pulses while held; total still 5 pulses.
//  5 bcd_in=8'h20: abort after 4 pulses -> IDLE with remaining=16, no done;
//    start pulsed during RUN has no effect.
//  6 reset asserted mid-run (remaining=07) -> all outputs 0 immediately, no done;
//    a new start after release behaves as in test 1.

Source files
------------

// File: rtl/bcd_pulse_gen_if.sv
// bcd_pulse_gen_if: control and status bundle for the BCD pulse generator.
interface bcd_pulse_gen_if #(
    parameter int NDIGITS = 2
);
    logic                   start;
    logic [4*NDIGITS-1:0]   bcd_in;
    logic                   hold;
    logic                   abort;
    logic                   pulse_out;
    logic [4*NDIGITS-1:0]   remaining;
    logic                   busy;
    logic                   done;
    logic                   err;
    modport master (
        output start, bcd_in, hold, abort,
        input  pulse_out, remaining, busy, done, err
    );
    modport slave (
        input  start, bcd_in, hold, abort,
        output pulse_out, remaining, busy, done, err
    );
endinterface

// File: rtl/bcd_pulse_gen.sv
// bcd_pulse_gen: loads a BCD count and emits that many pulses, PERIOD clocks apart,
// by counting a cascade of mod-10 digits down to zero, then strobes done.
module bcd_pulse_gen #(
    parameter int NDIGITS = 2,
    parameter int PERIOD  = 1
) (
    input logic             clk,
    input logic             reset,
    bcd_pulse_gen_if.slave  bus
);
    localparam int W  = 4 * NDIGITS;
    localparam int PW = $clog2(PERIOD) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d, rem_dec;
    logic [PW-1:0]  pre_q, pre_d;
    logic           pulse_q, pulse_d;
    logic           err_q, err_d;
    logic           bad_digit;
    logic           borrow;
    // Ripple the borrow through the digits; a zero digit wraps to 9 and passes it on.
    always_comb begin
        rem_dec   = rem_q;
        borrow    = 1'b1;
        bad_digit = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (borrow) begin
                rem_dec[4*i +: 4] = (rem_q[4*i +: 4] == 4'd0) ? 4'd9 : rem_q[4*i +: 4] - 4'd1;
                borrow            = (rem_q[4*i +: 4] == 4'd0);
            end
            bad_digit = bad_digit | (bus.bcd_in[4*i +: 4] > 4'd9);
        end
    end
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pre_d   = pre_q;
        pulse_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                if (bad_digit) err_d = 1'b1;
                else if (bus.bcd_in == '0) state_d = DONE;
                else begin
                    rem_d   = bus.bcd_in;
                    pre_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: if (bus.abort) state_d = IDLE;
            else if (!bus.hold) begin
                if (pre_q == PW'(PERIOD - 1)) begin
                    pulse_d = 1'b1;
                    pre_d   = '0;
                    rem_d   = rem_dec;
                    state_d = (rem_q == W'(1)) ? DONE : RUN;
                end else pre_d = pre_q + PW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            pre_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pre_q   <= pre_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end
    assign bus.pulse_out = pulse_q;
    assign bus.remaining = rem_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_pulse_gen.sv
// tb_bcd_pulse_gen: scoreboard bench; each pulse pops its expected remaining/done pair.
module tb_bcd_pulse_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    typedef struct {
        logic [7:0] rem;
        logic       last;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];
    bcd_pulse_gen_if #(.NDIGITS(2)) if1 ();
    bcd_pulse_gen_if #(.NDIGITS(2)) if3 ();
    bcd_pulse_gen #(.NDIGITS(2), .PERIOD(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    bcd_pulse_gen #(.NDIGITS(2), .PERIOD(3)) u3 (.clk(clk), .reset(reset), .bus(if3));
    always #5 clk = ~clk;
    always @(posedge clk) begin : mon1
        exp_t e;
        #1;
        if (!reset && if1.pulse_out) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL p1_pulse: unexpected pulse, remaining=%h", if1.remaining);
            end else begin
                e = q1.pop_front();
                if (if1.remaining !== e.rem || if1.done !== e.last) begin
                    miscompares++;
                    $display("FAIL p1_pulse: remaining=%h done=%b, required %h/%b", if1.remaining, if1.done, e.rem, e.last);
                end
            end
        end
    end
    always @(posedge clk) begin : mon3
        exp_t e;
        #1;
        if (!reset && if3.pulse_out) begin
            vectors++;
            if (q3.size() == 0) begin
                miscompares++;
                $display("FAIL p3_pulse: unexpected pulse, remaining=%h", if3.remaining);
            end else begin
                e = q3.pop_front();
                if (if3.remaining !== e.rem || if3.done !== e.last) begin
                    miscompares++;
                    $display("FAIL p3_pulse: remaining=%h done=%b, required %h/%b", if3.remaining, if3.done, e.rem, e.last);
                end
            end
        end
    end
    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction
    task automatic push_exp(input bit sel, input int n);
        exp_t e;
        for (int v = n - 1; v >= 0; v--) begin
            e.rem  = to_bcd(v);
            e.last = (v == 0);
            if (sel) q3.push_back(e);
            else q1.push_back(e);
        end
    endtask
    task automatic kick(input bit sel, input logic [7:0] v);
        if (sel) begin
            if3.start = 1'b1;
            if3.bcd_in = v;
        end else begin
            if1.start = 1'b1;
            if1.bcd_in = v;
        end
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        if3.start = 1'b0;
    endtask
    task automatic watch(input bit sel, input int n, output int pulses, output int busy_n,
                         output int done_n, output int err_n, output int first_p, output int done_at);
        pulses = 0; busy_n = 0; done_n = 0; err_n = 0; first_p = -1; done_at = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel ? if3.pulse_out : if1.pulse_out) begin
                pulses++;
                if (first_p < 0) first_p = i;
            end
            if (sel ? if3.busy : if1.busy) busy_n++;
            if (sel ? if3.err : if1.err) err_n++;
            if (sel ? if3.done : if1.done) begin
                done_n++;
                done_at = i;
            end
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({if1.pulse_out, if1.busy, if1.done, if1.err, if1.remaining} !== 12'h0 ||
            {if3.pulse_out, if3.busy, if3.done, if3.err, if3.remaining} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_state: u1=%b/%h u3=%b/%h, required all zero",
                     {if1.pulse_out, if1.busy, if1.done, if1.err}, if1.remaining,
                     {if3.pulse_out, if3.busy, if3.done, if3.err}, if3.remaining);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_count();
        int p, b, d, e, f, da;
        push_exp(0, 12);
        kick(0, 8'h12);
        watch(0, 16, p, b, d, e, f, da);
        vectors++;
        if (p !== 12 || b !== 12 || d !== 1 || da !== 12 || f !== 1 || q1.size() !== 0) begin
            miscompares++;
            $display("FAIL count_12: pulses=%0d busy=%0d done=%0d@%0d first=%0d left=%0d, required 12/12/1@12/1/0",
                     p, b, d, da, f, q1.size());
        end
    endtask
    task automatic test_period();
        int p, b, d, e, f, da;
        push_exp(1, 3);
        kick(1, 8'h03);
        watch(1, 14, p, b, d, e, f, da);
        vectors++;
        if (p !== 3 || b !== 9 || d !== 1 || da !== 9 || f !== 3 || q3.size() !== 0) begin
            miscompares++;
            $display("FAIL period_3: pulses=%0d busy=%0d done=%0d@%0d first=%0d left=%0d, required 3/9/1@9/3/0",
                     p, b, d, da, f, q3.size());
        end
    endtask
    task automatic test_abort();
        int p, b, d, e, f, da;
        push_exp(0, 20);
        kick(0, 8'h20);
        repeat (3) @(negedge clk);
        if1.start = 1'b1;
        if1.bcd_in = 8'h05;
        @(negedge clk);
        if1.start = 1'b0;
        vectors++;
        if (if1.remaining !== 8'h17 || if1.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_run: remaining=%h busy=%b, required 17/1", if1.remaining, if1.busy);
        end
        @(negedge clk);
        if1.abort = 1'b1;
        @(negedge clk);
        if1.abort = 1'b0;
        vectors++;
        if (if1.remaining !== 8'h16 || if1.busy !== 1'b0 || if1.pulse_out !== 1'b0 || if1.done !== 1'b0 || q1.size() !== 16) begin
            miscompares++;
            $display("FAIL abort: remaining=%h busy=%b pulse=%b done=%b left=%0d, required 16/0/0/0/16",
                     if1.remaining, if1.busy, if1.pulse_out, if1.done, q1.size());
        end
        q1.delete();
        watch(0, 5, p, b, d, e, f, da);
        vectors++;
        if (p !== 0 || d !== 0 || b !== 0 || if1.remaining !== 8'h16) begin
            miscompares++;
            $display("FAIL after_abort: pulses=%0d done=%0d busy=%0d remaining=%h, required 0/0/0/16", p, d, b, if1.remaining);
        end
    endtask
    task automatic test_err_zero();
        int p, b, d, e, f, da;
        kick(0, 8'h1A);
        watch(0, 5, p, b, d, e, f, da);
        vectors++;
        if (e !== 1 || p !== 0 || b !== 0 || d !== 0 || if1.remaining !== 8'h16) begin
            miscompares++;
            $display("FAIL err_digit: err=%0d pulses=%0d busy=%0d done=%0d remaining=%h, required 1/0/0/0/16",
                     e, p, b, d, if1.remaining);
        end
        kick(0, 8'hA1);
        watch(0, 3, p, b, d, e, f, da);
        vectors++;
        if (e !== 1 || p !== 0 || b !== 0) begin
            miscompares++;
            $display("FAIL err_high_digit: err=%0d pulses=%0d busy=%0d, required 1/0/0", e, p, b);
        end
        kick(0, 8'h00);
        watch(0, 5, p, b, d, e, f, da);
        vectors++;
        if (d !== 1 || da !== 0 || p !== 0 || b !== 0 || e !== 0) begin
            miscompares++;
            $display("FAIL zero_count: done=%0d@%0d pulses=%0d busy=%0d err=%0d, required 1@0/0/0/0", d, da, p, b, e);
        end
    endtask
    task automatic test_hold();
        int p, b, d, e, f, da;
        int bad;
        push_exp(0, 5);
        kick(0, 8'h05);
        repeat (3) @(negedge clk);
        if1.hold = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (if1.remaining !== 8'h03 || if1.pulse_out !== 1'b0 || if1.busy !== 1'b1) bad++;
        end
        if1.hold = 1'b0;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL hold_freeze: %0d held cycles moved, required 0", bad);
        end
        watch(0, 8, p, b, d, e, f, da);
        vectors++;
        if (p !== 3 || d !== 1 || da !== 2 || q1.size() !== 0) begin
            miscompares++;
            $display("FAIL hold_resume: pulses=%0d done=%0d@%0d left=%0d, required 3/1@2/0", p, d, da, q1.size());
        end
    endtask
    task automatic test_reset_midrun();
        int p, b, d, e, f, da;
        push_exp(0, 9);
        kick(0, 8'h09);
        repeat (3) @(negedge clk);
        vectors++;
        if (if1.remaining !== 8'h07) begin
            miscompares++;
            $display("FAIL pre_reset: remaining=%h, required 07", if1.remaining);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({if1.pulse_out, if1.busy, if1.done, if1.err} !== 4'b0 || if1.remaining !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset: flags=%b remaining=%h, required 0000/00",
                     {if1.pulse_out, if1.busy, if1.done, if1.err}, if1.remaining);
        end
        q1.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        watch(0, 4, p, b, d, e, f, da);
        vectors++;
        if (p !== 0 || d !== 0 || b !== 0) begin
            miscompares++;
            $display("FAIL post_reset: pulses=%0d done=%0d busy=%0d, required 0/0/0", p, d, b);
        end
        test_count();
    endtask
    initial begin
        {if1.start, if1.hold, if1.abort} = 3'b0;
        {if3.start, if3.hold, if3.abort} = 3'b0;
        if1.bcd_in = 8'h00;
        if3.bcd_in = 8'h00;
        test_reset();
        test_count();
        test_period();
        test_abort();
        test_err_zero();
        test_hold();
        test_reset_midrun();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
